// File: rtl/map_scanner_if.sv
// Map-store lookup bus and tile output stream between map_scanner and its neighbours.
// The scanner drives the master side; the map store / tile consumer sit on the slave side.
interface map_scanner_if;
    logic [2:0]  map_y;
    logic [6:0]  map_x;
    logic [3:0]  map_r;
    logic [3:0]  map_g;
    logic [3:0]  map_b;
    logic [2:0]  map_state;
    logic        tile_valid;
    logic        tile_ready;
    logic [2:0]  tile_row;
    logic [4:0]  tile_col;
    logic [11:0] tile_rgb;
    logic [2:0]  tile_state;

    modport master (
        output map_y, map_x,
        input  map_r, map_g, map_b, map_state,
        output tile_valid,
        input  tile_ready,
        output tile_row, tile_col, tile_rgb, tile_state
    );

    modport slave (
        input  map_y, map_x,
        output map_r, map_g, map_b, map_state,
        input  tile_valid,
        output tile_ready,
        input  tile_row, tile_col, tile_rgb, tile_state
    );
endinterface

// File: rtl/map_scanner.sv
// Scans a WIN_COLS x MAP_ROWS window of a wrapping tile map and streams one tile per cell.
// Optional macro MAP_SCANNER_SKIP_EMPTY_EN drops cells whose block state is 3'b000.
module map_scanner #(
    parameter int WIN_COLS = 16,
    parameter int MAP_ROWS = 5,
    parameter int MAP_COLS = 100
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [6:0]    scroll_x,
    output logic          busy,
    output logic          done,
    map_scanner_if.master bus
);
    localparam logic [2:0] LAST_ROW = 3'(MAP_ROWS - 1);
    localparam logic [4:0] LAST_COL = 5'(WIN_COLS - 1);
    localparam logic [6:0] LAST_X   = 7'(MAP_COLS - 1);
    localparam logic [6:0] COLS_W   = 7'(MAP_COLS);

    typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

    state_t      state_reg, state_next;
    logic [6:0]  base_reg;
    logic [2:0]  row_reg;
    logic [4:0]  col_reg;
    logic [6:0]  map_x_reg;
    logic [2:0]  map_y_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        tile_valid_reg;
    logic [2:0]  tile_row_reg;
    logic [4:0]  tile_col_reg;
    logic [2:0]  tile_state_reg;
    logic [11:0] tile_rgb_w;

    logic        skip_cell;
    logic        last_cell;
    logic        accept_start;
    logic        capture_en;
    logic        handshake;
    logic        advance;
    logic        finish_scan;
    logic [6:0]  base_new;

    // Folding scroll_x once at start keeps map_x inside 0..MAP_COLS-1 for the whole scan.
    assign base_new  = (scroll_x < COLS_W) ? scroll_x : (scroll_x - COLS_W);
    assign last_cell = (row_reg == LAST_ROW) && (col_reg == LAST_COL);

`ifdef MAP_SCANNER_SKIP_EMPTY_EN
    assign skip_cell = (bus.map_state == 3'b000);
`else
    assign skip_cell = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   state_next = CAPTURE;
            CAPTURE: begin
                if (skip_cell) begin
                    state_next = last_cell ? IDLE : ISSUE;
                end else begin
                    state_next = HOLD;
                end
            end
            HOLD:    if (bus.tile_ready) state_next = last_cell ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        accept_start = 1'b0;
        capture_en   = 1'b0;
        handshake    = 1'b0;
        advance      = 1'b0;
        finish_scan  = 1'b0;
        case (state_reg)
            IDLE:    accept_start = start;
            CAPTURE: begin
                capture_en = !skip_cell;
                advance    = skip_cell;
            end
            HOLD: begin
                handshake = bus.tile_ready;
                advance   = bus.tile_ready;
            end
            default: ;
        endcase
        finish_scan = advance && last_cell;
    end

    // Counters and map address move only on an accepted start or an advance, so the
    // map address is stable across ISSUE/CAPTURE/HOLD of every tile.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_reg  <= '0;
            row_reg   <= '0;
            col_reg   <= '0;
            map_x_reg <= '0;
            map_y_reg <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= finish_scan;
            if (accept_start) begin
                base_reg  <= base_new;
                row_reg   <= '0;
                col_reg   <= '0;
                map_x_reg <= base_new;
                map_y_reg <= '0;
                busy_reg  <= 1'b1;
            end else if (advance) begin
                if (last_cell) begin
                    busy_reg <= 1'b0;
                end else if (col_reg == LAST_COL) begin
                    col_reg   <= '0;
                    row_reg   <= row_reg + 3'd1;
                    map_x_reg <= base_reg;
                    map_y_reg <= row_reg + 3'd1;
                end else begin
                    col_reg   <= col_reg + 5'd1;
                    map_x_reg <= (map_x_reg == LAST_X) ? 7'd0 : (map_x_reg + 7'd1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_valid_reg <= 1'b0;
            tile_row_reg   <= '0;
            tile_col_reg   <= '0;
            tile_state_reg <= '0;
        end else if (capture_en) begin
            tile_valid_reg <= 1'b1;
            tile_row_reg   <= row_reg;
            tile_col_reg   <= col_reg;
            tile_state_reg <= bus.map_state;
        end else if (handshake) begin
            tile_valid_reg <= 1'b0;
        end
    end

    logic [3:0] chan_in [3];
    assign chan_in[0] = bus.map_r;
    assign chan_in[1] = bus.map_g;
    assign chan_in[2] = bus.map_b;

    // One capture register per colour channel; channel 0 (red) lands in the top nibble.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            logic [3:0] chan_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    chan_reg <= '0;
                end else if (capture_en) begin
                    chan_reg <= chan_in[gi];
                end
            end
            assign tile_rgb_w[4*(2-gi) +: 4] = chan_reg;
        end
    endgenerate

    assign bus.map_x      = map_x_reg;
    assign bus.map_y      = map_y_reg;
    assign bus.tile_valid = tile_valid_reg;
    assign bus.tile_row   = tile_row_reg;
    assign bus.tile_col   = tile_col_reg;
    assign bus.tile_rgb   = tile_rgb_w;
    assign bus.tile_state = tile_state_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
endmodule

// File: tb/tb_map_scanner.sv
// Scoreboard bench for map_scanner: scans push expected tiles, a negedge monitor pops on handshake.
// The map store is modelled combinationally from (map_y, map_x).
module tb_map_scanner;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [6:0] scroll_x;
    logic       busy;
    logic       done;
    logic       ready;

    always #5 clk = ~clk;

    map_scanner_if bus ();

    map_scanner #(.WIN_COLS(16), .MAP_ROWS(5), .MAP_COLS(100)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .scroll_x (scroll_x),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    // Map contents: every x with x%3==1 is empty, the far right columns are state 1, the rest state 2.
    function automatic logic [2:0] cell_state(input logic [6:0] x);
        if ((x % 3) == 1) return 3'b000;
        if (x >= 7'd90)   return 3'b001;
        return 3'b010;
    endfunction

    function automatic logic [11:0] cell_rgb(input logic [6:0] x, input logic [2:0] y);
        return {4'hF, 2'b00, y[1:0], x[3:0]};
    endfunction

    assign {bus.map_r, bus.map_g, bus.map_b} = cell_rgb(bus.map_x, bus.map_y);
    assign bus.map_state = cell_state(bus.map_x);
    assign bus.tile_ready = ready;

    typedef struct {
        logic [2:0]  row;
        logic [4:0]  col;
        logic [6:0]  x;
        logic [2:0]  y;
        logic [11:0] rgb;
        logic [2:0]  st;
    } tile_t;

    tile_t exp_q[$];
    tile_t mon_e;
    int tests = 0;
    int fails = 0;
    int tiles_seen = 0;
    int done_count = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h required=%0h", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, got);
        end
    endtask

    // Monitor: a handshake happens on the coming rising edge whenever valid&ready and no reset.
    always @(negedge clk) begin
        if (done) done_count++;
        if (!rst && bus.tile_valid && ready) begin
            tiles_seen++;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_tile row=%0d col=%0d rgb=%h", bus.tile_row, bus.tile_col, bus.tile_rgb);
            end else begin
                mon_e = exp_q.pop_front();
                if (bus.tile_row !== mon_e.row || bus.tile_col !== mon_e.col || bus.tile_rgb !== mon_e.rgb ||
                    bus.tile_state !== mon_e.st || bus.map_x !== mon_e.x || bus.map_y !== mon_e.y) begin
                    fails++;
                    $display("FAIL tile%0d got r%0d c%0d x%0d y%0d rgb %h st %b required r%0d c%0d x%0d y%0d rgb %h st %b",
                             tiles_seen, bus.tile_row, bus.tile_col, bus.map_x, bus.map_y, bus.tile_rgb, bus.tile_state,
                             mon_e.row, mon_e.col, mon_e.x, mon_e.y, mon_e.rgb, mon_e.st);
                end else begin
                    $display("[TB] tile r%0d c%0d x%0d rgb %h st %b", mon_e.row, mon_e.col, mon_e.x, mon_e.rgb, mon_e.st);
                end
            end
        end
    end

    task automatic push_scan(input int scroll, output int n);
        int base;
        tile_t t;
        n = 0;
        base = (scroll < 100) ? scroll : scroll - 100;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 16; c++) begin
                t.row = 3'(r);
                t.col = 5'(c);
                t.x   = 7'((base + c) % 100);
                t.y   = 3'(r);
                t.rgb = cell_rgb(t.x, t.y);
                t.st  = cell_state(t.x);
`ifdef MAP_SCANNER_SKIP_EMPTY_EN
                if (t.st == 3'b000) continue;
`endif
                exp_q.push_back(t);
                n++;
            end
        end
    endtask

    // scroll_x is scrambled right after the start so a late change would corrupt map_x.
    task automatic pulse_start(input logic [6:0] sx);
        @(posedge clk); #1;
        scroll_x = sx;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        scroll_x = 7'd127;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_valid"}, {63'd0, bus.tile_valid}, 64'd0);
        check({tag, "_busy_done"}, {62'd0, busy, done}, 64'd0);
        check({tag, "_map_xy"}, {54'd0, bus.map_x, bus.map_y}, 64'd0);
        check({tag, "_tile"}, {41'd0, bus.tile_row, bus.tile_col, bus.tile_rgb, bus.tile_state}, 64'd0);
    endtask

    task automatic wait_done(input string tag);
        int k;
        for (k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (done) break;
        end
        if (k == 3000) begin
            tests++;
            fails++;
            $display("FAIL %s_done_timeout waited=%0d cycles required done pulse", tag, k);
        end else begin
            check({tag, "_busy_at_done"}, {63'd0, busy}, 64'd0);
        end
    endtask

    task automatic finish_checks(input string tag, input int n, input int s0, input int d0);
        repeat (3) @(negedge clk);
        check({tag, "_tile_count"}, 64'(tiles_seen - s0), 64'(n));
        check({tag, "_done_pulses"}, 64'(done_count - d0), 64'd1);
        check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_idle"}, {62'd0, busy, done}, 64'd0);
    endtask

    task automatic run_scan(input string tag, input logic [6:0] sx);
        int n, s0, d0;
        s0 = tiles_seen;
        d0 = done_count;
        push_scan(int'(sx), n);
        pulse_start(sx);
        wait_done(tag);
        finish_checks(tag, n, s0, d0);
    endtask

    initial begin
        int n, s0, d0, k;
        rst = 1'b1;
        start = 1'b0;
        scroll_x = 7'd0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        run_scan("scan0", 7'd0);
        run_scan("wrap98", 7'd98);
        run_scan("fold120", 7'd120);

        // Backpressure on the first tile for 10 cycles.
        ready = 1'b0;
        s0 = tiles_seen;
        d0 = done_count;
        push_scan(5, n);
        pulse_start(7'd5);
        for (k = 0; k < 200; k++) begin
            @(negedge clk);
            if (bus.tile_valid) break;
        end
        check("hold_first_valid", {63'd0, bus.tile_valid}, 64'd1);
        for (int i = 0; i < 10; i++) begin
            check("hold_tile", {31'd0, bus.tile_valid, bus.tile_row, bus.tile_col, bus.tile_rgb, bus.tile_state,
                                bus.map_x, bus.map_y},
                  {31'd0, 1'b1, exp_q[0].row, exp_q[0].col, exp_q[0].rgb, exp_q[0].st, exp_q[0].x, exp_q[0].y});
            @(negedge clk);
        end
        @(posedge clk); #1 ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("hold_accepted", 64'(tiles_seen - s0), 64'd1);
        check("hold_valid_drop", {63'd0, bus.tile_valid}, 64'd0);
        wait_done("hold");
        finish_checks("hold", n, s0, d0);

        // A second start mid-scan must be ignored.
        s0 = tiles_seen;
        d0 = done_count;
        push_scan(10, n);
        pulse_start(7'd10);
        repeat (7) @(posedge clk);
        #1 scroll_x = 7'd50;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_done("restart");
        finish_checks("restart", n, s0, d0);

        // Reset right after the 20th accepted tile.
        s0 = tiles_seen;
        d0 = done_count;
        push_scan(0, n);
        pulse_start(7'd0);
        for (k = 0; k < 2000; k++) begin
            @(posedge clk);
            if (tiles_seen - s0 >= 20) break;
        end
        #1 rst = 1'b1;
        exp_q.delete();
        check("midrst_tiles", 64'(tiles_seen - s0), 64'd20);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_reset_values("midrst");
        repeat (5) @(negedge clk);
        check("midrst_no_done", 64'(done_count - d0), 64'd0);
        run_scan("after_rst", 7'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
